// File: rtl/memory.sv
// MEM stage: 1024x64 data RAM plus MEM/WB pipeline register.
// MEM_BOUNDS_CHECK_EN enables dropping out-of-range loads/stores.
module memory #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] ALUResult,
  input  logic [63:0] WriteData,
  input  logic [4:0]  Rd,
  input  logic        Zero,
  input  logic        BranchTaken,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  output logic [63:0] ReadData,
  output logic [63:0] ALUResultOut,
  output logic [4:0]  RdOut,
  output logic        BranchTakenOut,
  output logic        MemtoRegOut,
  output logic        RegWriteOut
);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          in_range;
  logic          unused_zero;

  assign idx         = ALUResult[AW+2:3];
  assign unused_zero = Zero;

`ifdef MEM_BOUNDS_CHECK_EN
  assign in_range = (ALUResult[63:AW+3] == '0);
`else
  assign in_range = 1'b1;
`endif

  // RAM is cleared by reset, so it is a plain register array
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (MemWrite && in_range) begin
      mem[idx] <= WriteData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ReadData       <= '0;
      ALUResultOut   <= '0;
      RdOut          <= '0;
      BranchTakenOut <= 1'b0;
      MemtoRegOut    <= 1'b0;
      RegWriteOut    <= 1'b0;
    end else begin
      ReadData       <= (MemRead && in_range)
                        ? mem[idx] : '0;
      ALUResultOut   <= ALUResult;
      RdOut          <= Rd;
      BranchTakenOut <= BranchTaken;
      MemtoRegOut    <= MemtoReg;
      RegWriteOut    <= RegWrite;
    end
  end

endmodule

// File: tb/tb_memory.sv
// Directed bench for the MEM stage.
// Out-of-range expectations follow MEM_BOUNDS_CHECK_EN.
module tb_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] ALUResult, WriteData;
  logic [4:0]  Rd;
  logic        Zero, BranchTaken, MemRead, MemWrite;
  logic        MemtoReg, RegWrite;
  logic [63:0] ReadData, ALUResultOut;
  logic [4:0]  RdOut;
  logic        BranchTakenOut, MemtoRegOut, RegWriteOut;

  int n_chk = 0;
  int n_fail = 0;

  memory dut (
    .clk(clk), .reset(reset),
    .ALUResult(ALUResult), .WriteData(WriteData),
    .Rd(Rd), .Zero(Zero), .BranchTaken(BranchTaken),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ReadData(ReadData), .ALUResultOut(ALUResultOut),
    .RdOut(RdOut), .BranchTakenOut(BranchTakenOut),
    .MemtoRegOut(MemtoRegOut), .RegWriteOut(RegWriteOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [63:0] a,
                    input logic [63:0] wd,
                    input logic        mr,
                    input logic        mw,
                    input logic [4:0]  rd,
                    input logic        br,
                    input logic        m2r,
                    input logic        rw);
    ALUResult   = a;
    WriteData   = wd;
    MemRead     = mr;
    MemWrite    = mw;
    Rd          = rd;
    BranchTaken = br;
    MemtoReg    = m2r;
    RegWrite    = rw;
    Zero        = ~Zero;
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [63:0] a,
                    input logic [63:0] wd);
    op(a, wd, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ld(input logic [63:0] a);
    op(a, 64'h0, 1'b1, 1'b0, 5'd1, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd"},  ReadData, 64'h0);
    chk({tag, "_alu"}, ALUResultOut, 64'h0);
    chk({tag, "_rdo"}, {59'h0, RdOut}, 64'h0);
    chk({tag, "_ctl"},
        {61'h0, BranchTakenOut, MemtoRegOut, RegWriteOut},
        64'h0);
  endtask

  logic [63:0] exp_oor_ld;
  logic [63:0] exp_alias;

  initial begin
`ifdef MEM_BOUNDS_CHECK_EN
    exp_oor_ld = 64'h0;
    exp_alias  = 64'hAAAAAAAAAAAAAAAA;
`else
    exp_oor_ld = 64'hAAAAAAAAAAAAAAAA;
    exp_alias  = 64'h0000000000000077;
`endif
    reset = 1'b0;
    ALUResult = '0; WriteData = '0; Rd = '0;
    Zero = 1'b0; BranchTaken = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0;
    MemtoReg = 1'b0; RegWrite = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;

    st(64'h10, 64'hDEADBEEFDEADBEEF);
    chk("st_rd0", ReadData, 64'h0);
    op(64'h10, 64'h0, 1'b1, 1'b0, 5'd13, 1'b0, 1'b1, 1'b1);
    chk("ld10", ReadData, 64'hDEADBEEFDEADBEEF);
    chk("ld10_rdout", {59'h0, RdOut}, 64'd13);
    chk("ld10_m2r", {63'h0, MemtoRegOut}, 64'd1);
    chk("ld10_rw", {63'h0, RegWriteOut}, 64'd1);
    chk("ld10_br", {63'h0, BranchTakenOut}, 64'd0);
    chk("ld10_alu", ALUResultOut, 64'h10);

    st(64'h20, 64'h1234567890ABCDEF);
    ld(64'h20);
    chk("ld20", ReadData, 64'h1234567890ABCDEF);
    ld(64'h10);
    chk("reld10", ReadData, 64'hDEADBEEFDEADBEEF);
    ld(64'h17);
    chk("ld17_unaligned", ReadData, 64'hDEADBEEFDEADBEEF);

    op(64'h30, 64'h0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("br_out", {63'h0, BranchTakenOut}, 64'd1);
    chk("br_rd0", ReadData, 64'h0);
    chk("br_alu", ALUResultOut, 64'h30);
    op(64'h30, 64'h0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
    chk("br_drop", {63'h0, BranchTakenOut}, 64'd0);

    st(64'h0, 64'hAAAAAAAAAAAAAAAA);
    st(64'h1FF8, 64'h5555555555555555);
    ld(64'h0);
    chk("ld0", ReadData, 64'hAAAAAAAAAAAAAAAA);
    ld(64'h1FF8);
    chk("ld1ff8", ReadData, 64'h5555555555555555);
    ld(64'h2000);
    chk("ld2000", ReadData, exp_oor_ld);
    st(64'h2000, 64'h77);
    ld(64'h0);
    chk("st2000_alias", ReadData, exp_alias);

    op(64'h0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1,
       5'd5, 1'b1, 1'b1, 1'b1);
    op(64'h8, 64'h0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b1);
    chk("pre_rst_alu", ALUResultOut, 64'h8);
    reset = 1'b0;
    #1;
    chk_all_zero("async_rst");
    op(64'h10, 64'h99, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1);
    chk_all_zero("held_rst");
    reset = 1'b1;
    ld(64'h0);
    chk("post_rst_ld0", ReadData, 64'h0);
    ld(64'h10);
    chk("post_rst_ld10", ReadData, 64'h0);
    ld(64'h1FF8);
    chk("post_rst_ld1ff8", ReadData, 64'h0);

    st(64'h40, 64'h1);
    op(64'h40, 64'h2, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b1);
    chk("rbw_old", ReadData, 64'h1);
    ld(64'h40);
    chk("rbw_new", ReadData, 64'h2);
    op(64'h40, 64'h3, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    chk("wr_only_rd0", ReadData, 64'h0);
    ld(64'h40);
    chk("ld40_3", ReadData, 64'h3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/memory.md
# memory

Data-memory (MEM) stage of the single-issue RISC-V datapath, between execute and write-back. Holds a 1024 x 64-bit data RAM addressed by the byte address in `ALUResult`, performs doubleword loads and stores, and registers the results together with the write-back control fields into the MEM/WB boundary.

## Interface
- Parameters:
  - `DEPTH`, default 1024, number of 64-bit words; must be a power of two.
  - `AW`, default 10, word-index width = log2(DEPTH).
- Ports:
  - `clk` in 1: rising-edge clock.
  - `reset` in 1: asynchronous, active-low reset (asserted when 0).
  - `ALUResult` in 64: byte address for loads/stores; also the pass-through result.
  - `WriteData` in 64: store data.
  - `Rd` in 5: destination register.
  - `Zero` in 1: ALU zero flag; accepted and ignored.
  - `BranchTaken` in 1: resolved branch decision.
  - `MemRead` in 1: load enable.
  - `MemWrite` in 1: store enable.
  - `MemtoReg` in 1: write-back select.
  - `RegWrite` in 1: register-file write enable.
  - `ReadData` out 64: registered load data.
  - `ALUResultOut` out 64: registered `ALUResult`.
  - `RdOut` out 5: registered `Rd`.
  - `BranchTakenOut` out 1: registered `BranchTaken`.
  - `MemtoRegOut` out 1: registered `MemtoReg`.
  - `RegWriteOut` out 1: registered `RegWrite`.

## Operation
- Word index: `ALUResult[AW+2:3]`. `ALUResult[2:0]` is ignored; no misalignment fault.
- In range: `ALUResult < DEPTH*8` (0x0000–0x1FF8 at default).
- Store: on a rising edge with `MemWrite`=1 and the address in range, `mem[idx] <= WriteData`.
- Load: on a rising edge with `MemRead`=1 and the address in range, `ReadData <= mem[idx]`. Otherwise `ReadData <= 0`. This includes `MemRead`=0, out-of-range addresses, and `MemWrite`=1 without `MemRead`.
- `MemRead`=1 and `MemWrite`=1 on the same address in the same edge is read-before-write: `ReadData` gets the old word and the RAM gets the new one.
- Pass-through registers: `ALUResultOut`, `RdOut`, `BranchTakenOut`, `MemtoRegOut` and `RegWriteOut` capture their inputs every rising edge, unconditionally.
- Reset (`reset`=0, asynchronous):
  - All outputs go to 0 immediately.
  - Every RAM word is cleared to 0.
  - Stores are blocked while reset is held.
  - A store in flight when reset asserts is lost.

## Timing
- One-cycle latency for all outputs: values presented before edge N appear after edge N.
- Store data is visible to a load issued in the following cycle, i.e. sampled at the next edge.
- No handshake and no stall; one access per cycle.
- Reset release is recognised at the first rising edge after `reset` returns to 1.

## Configuration
- `MEM_BOUNDS_CHECK_EN`:
  - Defined: out-of-range stores are dropped and out-of-range loads return 0, as above.
  - Undefined: no range check. The index is `ALUResult[AW+2:3]` and the address wraps modulo `DEPTH*8`, so 0x2000 aliases 0x0000.
- The test plan assumes the macro is defined.

## Test plan
- Store 0xDEADBEEFDEADBEEF at 0x10, then load 0x10 with `MemtoReg`=1, `RegWrite`=1, `Rd`=13 -> `ReadData`=0xDEADBEEFDEADBEEF, `RdOut`=13, `MemtoRegOut`=1, `BranchTakenOut`=0.
- Store 0x1234567890ABCDEF at 0x20, then load 0x20 -> `ReadData`=0x1234567890ABCDEF. A reload of 0x10 still returns 0xDEADBEEFDEADBEEF.
- `ALUResult`=0x30, `BranchTaken`=1, `MemRead`=0 -> after one edge `BranchTakenOut`=1, `ReadData`=0, `ALUResultOut`=0x30. Dropping `BranchTaken` -> `BranchTakenOut`=0 next cycle.
- Boundaries:
  - Store 0xAAAAAAAAAAAAAAAA at 0x0 and 0x5555555555555555 at 0x1FF8, then load each -> stored values returned.
  - Load 0x2000 -> `ReadData`=0.
  - A store at 0x2000 leaves 0x0 unchanged.
- Store 0xFFFFFFFFFFFFFFFF at 0x0, pulse `reset` low for one cycle -> all outputs 0 during reset. A later load of 0x0 returns 0.
- Same-edge load+store to 0x40 holding 0x1 with new data 0x2 -> `ReadData`=0x1. The next load returns 0x2.
